// File: rtl/piso_bit_counter.sv
`default_nettype none
// ============================================================================
// Module      : piso_bit_counter
// Description : Counts bits consumed in the current word of the PISO
//               transmitter. Synchronous clear has priority over increment.
//               'last' flags the final bit position (cnt == WIDTH-1).
// Ports       : clk  - clock
//               rst  - asynchronous active-high reset
//               clr  - return the count to zero on the next edge
//               inc  - advance the count by one on the next edge
//               cnt  - current bit count, $clog2(WIDTH) bits
//               last - high while cnt points at the final bit
// Revision    : 1.0 - initial release
// ============================================================================
module piso_bit_counter #(
   parameter int WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     inc,
   output logic [$clog2(WIDTH)-1:0] cnt,
   output logic                     last
);

   localparam int                 CNT_W      = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]   c_last_cnt = CNT_W'(WIDTH - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (inc) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign cnt  = r_cnt;
   assign last = (r_cnt == c_last_cnt);

endmodule
`default_nettype wire

// File: rtl/piso_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : piso_shift_reg
// Description : Parallel-in serial-out transmitter. A word is captured on a
//               load/ready handshake and shifted out one bit per enabled
//               clock. A load offered together with the final enabled bit
//               chains the next word with no idle gap.
// Ports       : clk   - clock
//               rst   - asynchronous active-high reset
//               load  - request to capture din (honoured only when ready=1)
//               din   - parallel word, WIDTH bits
//               en    - shift enable; current bit consumed on an enabled edge
//               ready - load will be accepted this cycle (combinational)
//               sout  - serial data out (IDLE_LEVEL while not busy)
//               busy  - a word is being transmitted
//               done  - one-cycle pulse after a word's last bit is consumed
// Revision    : 1.0 - initial release
// ============================================================================
module piso_shift_reg #(
   parameter int   WIDTH      = 4,
   parameter bit   MSB_FIRST  = 1'b1,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             en,
   output logic             ready,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   localparam int       CNT_W     = $clog2(WIDTH);
   localparam int       c_out_bit = MSB_FIRST ? (WIDTH - 1) : 0;
   localparam logic [0:0] c_idle  = 1'b0;
   localparam logic [0:0] c_shift = 1'b1;

   logic [0:0]       r_state;
   logic [WIDTH-1:0] r_shreg;
   logic             r_done;

   logic [WIDTH-1:0] w_shifted;
   logic [CNT_W-1:0] w_cnt;
   logic             w_last;
   logic             w_busy;
   logic             w_clr;
   logic             w_inc;

   assign w_busy = (r_state == c_shift);

   // Counter restarts on every accepted word and at the end of every word,
   // so it always reads zero in IDLE.
   assign w_clr  = (!w_busy && load) || (w_busy && en && w_last);
   assign w_inc  = w_busy && en && !w_last;

   piso_bit_counter #(
      .WIDTH (WIDTH)
   ) u_bit_counter (
      .clk  (clk),
      .rst  (rst),
      .clr  (w_clr),
      .inc  (w_inc),
      .cnt  (w_cnt),
      .last (w_last)
   );

   // Shift toward the output bit, back-filling with zero.
   generate
      if (MSB_FIRST) begin : g_msb_first
         assign w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
      end else begin : g_lsb_first
         assign w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_idle;
         r_shreg <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == c_idle) begin
            if (load) begin
               r_shreg <= din;
               r_state <= c_shift;
            end
         end else if (en) begin
            if (w_last) begin
               r_done <= 1'b1;
               if (load) begin
                  r_shreg <= din;
               end else begin
                  r_state <= c_idle;
               end
            end else begin
               r_shreg <= w_shifted;
            end
         end
      end
   end

   // cnt only feeds 'last'; the explicit compare keeps all of it in use.
   assign ready = !w_busy || (en && w_last && (w_cnt == CNT_W'(WIDTH - 1)));
   assign busy  = w_busy;
   assign done  = r_done;
   assign sout  = w_busy ? r_shreg[c_out_bit] : IDLE_LEVEL;

endmodule
`default_nettype wire
